// File: rtl/cpu_types_pkg.sv
// Shared types for the request sequencer.
//   word_t     : 32-bit instruction / data word
//   reqstate_t : request sequencer states
//   WD_W       : width of the stall watchdog counter
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEM,
    HALT
  } reqstate_t;

  localparam int WD_W = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter. It holds at all-ones instead of wrapping.
// Ports:
//   CLK   : clock, rising edge
//   nRST  : asynchronous active-low reset, clears count
//   en    : increment this cycle
//   clr   : synchronous clear, takes priority over en
//   count : current value
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/request_unit.sv
// Memory request sequencer between control_unit and the cache side of
// datapath_cache_if. It fetches an instruction, presents it to decode,
// issues any data request, and pulses pc_en when the instruction retires.
// Ports:
//   CLK, nRST                : clock (rising edge) and async active-low reset
//   ihit, imemload           : instruction cache hit and word
//   dhit                     : data cache hit
//   dREN_in, dWEN_in, halt_in: decode results from control_unit (EXEC only)
//   imemREN, dmemREN, dmemWEN: cache requests
//   instr, instr_valid       : latched instruction and decode strobe
//   pc_en                    : one-cycle retire pulse
//   halt, req_err, hung      : sticky status
//   cycle_cnt, instr_cnt     : saturating active-cycle and retire counters
//
// state | meaning
// IDLE  | one cycle after reset, no requests
// FETCH | imemREN asserted, waiting for ihit
// EXEC  | instr presented to decode, choose next step
// MEM   | latched data request asserted, waiting for dhit
// HALT  | absorbing until reset, halt asserted
module request_unit
  import cpu_types_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  word_t            imemload,
  input  logic             dhit,
  input  logic             dREN_in,
  input  logic             dWEN_in,
  input  logic             halt_in,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output word_t            instr,
  output logic             instr_valid,
  output logic             pc_en,
  output logic             halt,
  output logic             req_err,
  output logic             hung,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  reqstate_t       state, next_state;
  logic            req_rd, req_wr;
  logic            hung_q;
  logic            waiting, expire, wd_clr, cycle_en;
  logic [WD_W-1:0] wait_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  next_state = FETCH;
      FETCH: if (ihit) next_state = EXEC;
      EXEC: begin
        if (halt_in)                 next_state = HALT;
        else if (dREN_in || dWEN_in) next_state = MEM;
        else                         next_state = FETCH;
      end
      MEM:   if (dhit) next_state = FETCH;
      HALT:  next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  // Requests are decoded from state only, so an async reset removes them
  // in the same instant. pc_en also looks at the hit/decode inputs.
  always_comb begin
    imemREN     = 1'b0;
    dmemREN     = 1'b0;
    dmemWEN     = 1'b0;
    instr_valid = 1'b0;
    pc_en       = 1'b0;
    halt        = 1'b0;
    case (state)
      FETCH: imemREN = 1'b1;
      EXEC: begin
        instr_valid = 1'b1;
        pc_en       = !halt_in && !dREN_in && !dWEN_in;
      end
      MEM: begin
        dmemREN = req_rd;
        dmemWEN = req_wr;
        pc_en   = dhit;
      end
      HALT: halt = 1'b1;
      default: ;
    endcase
  end

  // A simultaneous read and write request is resolved as a write only.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      instr   <= '0;
      req_rd  <= 1'b0;
      req_wr  <= 1'b0;
      req_err <= 1'b0;
      hung_q  <= 1'b0;
    end else begin
      if (state == FETCH && ihit) instr <= imemload;
      if (state == EXEC) begin
        req_rd <= dREN_in && !dWEN_in;
        req_wr <= dWEN_in;
        if (dREN_in && dWEN_in) req_err <= 1'b1;
      end
      if (expire) hung_q <= 1'b1;
    end
  end

  // Watchdog: wait_cnt counts missed cycles since entering FETCH/MEM.
  assign waiting = (state == FETCH) || (state == MEM);
  assign wd_clr  = ((next_state == FETCH) || (next_state == MEM)) &&
                   (next_state != state);
  assign expire  = (TIMEOUT != 0) && waiting && (wait_cnt == WD_W'(TIMEOUT));
  assign hung    = hung_q || expire;

  sat_counter #(.W(WD_W)) u_wait_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .en    ((state == FETCH && !ihit) || (state == MEM && !dhit)),
    .clr   (wd_clr),
    .count (wait_cnt)
  );

  assign cycle_en = (state == FETCH) || (state == EXEC) || (state == MEM);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .en    (cycle_en),
    .clr   (1'b0),
    .count (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .en    (pc_en),
    .clr   (1'b0),
    .count (instr_cnt)
  );

endmodule
